// File: rtl/rgb2ycbcr_stream.sv
// Three-stage RGB888 -> YCbCr (BT.601, 8-bit fixed-point) converter with valid/ready and a line-end tag.
// Define RGB2YCBCR_SKID_EN to add a 2-entry input skid buffer with a registered in_ready.
module rgb2ycbcr_stream #(
  parameter int Y_OFFSET = 0,
  parameter int C_OFFSET = 128,
  parameter int SAT_MIN  = 0,
  parameter int SAT_MAX  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] Y,
  output logic [7:0] Cb,
  output logic [7:0] Cr,
  output logic       out_last
);

  typedef logic signed [17:0] acc_t;

  localparam acc_t K_YR  = 18'sd77;
  localparam acc_t K_YG  = 18'sd150;
  localparam acc_t K_YB  = 18'sd29;
  localparam acc_t K_CBR = -18'sd43;
  localparam acc_t K_CBG = -18'sd85;
  localparam acc_t K_CBB = 18'sd128;
  localparam acc_t K_CRR = 18'sd128;
  localparam acc_t K_CRG = -18'sd107;
  localparam acc_t K_CRB = -18'sd21;
  localparam acc_t RND   = 18'sd128;
  localparam acc_t Y_OFF = acc_t'(Y_OFFSET);
  localparam acc_t C_OFF = acc_t'(C_OFFSET);

  function automatic acc_t mul_coef(input logic [7:0] x, input acc_t k);
    return acc_t'({10'd0, x}) * k;
  endfunction

  // Saturate instead of wrapping: out-of-range results pin to the clamp bounds.
  function automatic logic [7:0] clamp_px(input acc_t sum, input acc_t offs);
    acc_t v;
    v = (sum >>> 4'd8) + offs;
    if (v < acc_t'(SAT_MIN)) begin
      return 8'(SAT_MIN);
    end else if (v > acc_t'(SAT_MAX)) begin
      return 8'(SAT_MAX);
    end else begin
      return v[7:0];
    end
  endfunction

  logic       adv_s;
  logic       feed_valid_s;
  logic [7:0] feed_r_s, feed_g_s, feed_b_s;
  logic       feed_last_s;

  logic       s1_valid_r, s1_last_r;
  acc_t       prod_r [9];
  logic       s2_valid_r, s2_last_r;
  acc_t       sum_y_r, sum_cb_r, sum_cr_r;
  logic       out_valid_r, out_last_r;
  logic [7:0] y_r, cb_r, cr_r;

  // The whole pipe moves together unless the output holds a pixel nobody takes.
  assign adv_s = !out_valid_r || out_ready;

`ifdef RGB2YCBCR_SKID_EN
  logic [24:0] skid_mem_r [2];
  logic        skid_wr_ptr_r, skid_rd_ptr_r;
  logic [1:0]  skid_cnt_r;
  logic [1:0]  skid_cnt_nxt_s;
  logic        in_ready_r;
  logic        push_s, pop_s;

  assign push_s = in_valid && in_ready_r;
  assign pop_s  = adv_s && (skid_cnt_r != 2'd0);

  // Next skid occupancy from concurrent push/pop.
  always_comb begin
    skid_cnt_nxt_s = skid_cnt_r;
    if (push_s && !pop_s) begin
      skid_cnt_nxt_s = skid_cnt_r + 2'd1;
    end else if (pop_s && !push_s) begin
      skid_cnt_nxt_s = skid_cnt_r - 2'd1;
    end else begin
      skid_cnt_nxt_s = skid_cnt_r;
    end
  end

  // Skid storage; in_ready is registered from the next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_mem_r[0] <= 25'd0;
      skid_mem_r[1] <= 25'd0;
      skid_wr_ptr_r <= 1'b0;
      skid_rd_ptr_r <= 1'b0;
      skid_cnt_r    <= 2'd0;
      in_ready_r    <= 1'b1;
    end else begin
      if (push_s) begin
        skid_mem_r[skid_wr_ptr_r] <= {in_last, R, G, B};
        skid_wr_ptr_r             <= ~skid_wr_ptr_r;
      end
      if (pop_s) begin
        skid_rd_ptr_r <= ~skid_rd_ptr_r;
      end
      skid_cnt_r <= skid_cnt_nxt_s;
      in_ready_r <= (skid_cnt_nxt_s != 2'd2);
    end
  end

  assign feed_valid_s = (skid_cnt_r != 2'd0);
  assign {feed_last_s, feed_r_s, feed_g_s, feed_b_s} = skid_mem_r[skid_rd_ptr_r];
  assign in_ready     = in_ready_r;
`else
  assign feed_valid_s = in_valid;
  assign feed_r_s     = R;
  assign feed_g_s     = G;
  assign feed_b_s     = B;
  assign feed_last_s  = in_last;
  assign in_ready     = adv_s;
`endif

  // S1: capture the nine coefficient products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        prod_r[i] <= 18'sd0;
      end
    end else if (adv_s) begin
      s1_valid_r <= feed_valid_s;
      if (feed_valid_s) begin
        s1_last_r <= feed_last_s;
        prod_r[0] <= mul_coef(feed_r_s, K_YR);
        prod_r[1] <= mul_coef(feed_g_s, K_YG);
        prod_r[2] <= mul_coef(feed_b_s, K_YB);
        prod_r[3] <= mul_coef(feed_r_s, K_CBR);
        prod_r[4] <= mul_coef(feed_g_s, K_CBG);
        prod_r[5] <= mul_coef(feed_b_s, K_CBB);
        prod_r[6] <= mul_coef(feed_r_s, K_CRR);
        prod_r[7] <= mul_coef(feed_g_s, K_CRG);
        prod_r[8] <= mul_coef(feed_b_s, K_CRB);
      end
    end
  end

  // S2: per-component sums with the rounding constant folded in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      sum_y_r    <= 18'sd0;
      sum_cb_r   <= 18'sd0;
      sum_cr_r   <= 18'sd0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_last_r <= s1_last_r;
        sum_y_r   <= prod_r[0] + prod_r[1] + prod_r[2] + RND;
        sum_cb_r  <= prod_r[3] + prod_r[4] + prod_r[5] + RND;
        sum_cr_r  <= prod_r[6] + prod_r[7] + prod_r[8] + RND;
      end
    end
  end

  // S3: shift, offset and clamp into the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      y_r         <= 8'd0;
      cb_r        <= 8'd0;
      cr_r        <= 8'd0;
    end else if (adv_s) begin
      out_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        out_last_r <= s2_last_r;
        y_r        <= clamp_px(sum_y_r, Y_OFF);
        cb_r       <= clamp_px(sum_cb_r, C_OFF);
        cr_r       <= clamp_px(sum_cr_r, C_OFF);
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign Y         = y_r;
  assign Cb        = cb_r;
  assign Cr        = cr_r;

endmodule

// File: tb/tb_rgb2ycbcr_stream.sv
// Bench for rgb2ycbcr_stream: corner-vector table, random backpressure against an arithmetic model,
// line tag timing, stall behaviour and mid-stream reset. Honours RGB2YCBCR_SKID_EN for latency.
module tb_rgb2ycbcr_stream;

`ifdef RGB2YCBCR_SKID_EN
  localparam int   LAT  = 4;
  localparam logic SKID = 1'b1;
`else
  localparam int   LAT  = 3;
  localparam logic SKID = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, out_ready;
  logic [7:0] R, G, B;
  logic       in_ready, out_valid, out_last;
  logic [7:0] Y, Cb, Cr;
  logic       in_ready16, out_valid16, last16;
  logic [7:0] y16, cb16, cr16;

  always #5 clk = ~clk;

  rgb2ycbcr_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .R(R), .G(G), .B(B), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .Cb(Cb), .Cr(Cr), .out_last(out_last)
  );

  rgb2ycbcr_stream #(.Y_OFFSET(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .R(R), .G(G), .B(B), .in_last(in_last),
    .out_valid(out_valid16), .out_ready(out_ready),
    .Y(y16), .Cb(cb16), .Cr(cr16), .out_last(last16)
  );

  typedef struct {
    logic [7:0] y, cb, cr, y16;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0] r, g, b, y, cb, cr, y16;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  exp_t exp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Reference: plain integer arithmetic with floor division by 256 and saturation.
  function automatic int fdiv256(input int v);
    if (v >= 0) return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic logic [7:0] sat8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic exp_t model(input int r, input int g, input int b, input logic last);
    exp_t e;
    int   yv, cbv, crv;
    yv     = fdiv256(77 * r + 150 * g + 29 * b + 128);
    cbv    = fdiv256(-43 * r - 85 * g + 128 * b + 128);
    crv    = fdiv256(128 * r - 107 * g - 21 * b + 128);
    e.y    = sat8(yv);
    e.y16  = sat8(yv + 16);
    e.cb   = sat8(cbv + 128);
    e.cr   = sat8(crv + 128);
    e.last = last;
    return e;
  endfunction

  logic        prev_stall = 1'b0;
  logic [24:0] held;

  // Scoreboard: in-order compare on every output handshake, hold check across stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 64'({out_valid, Y, Cb, Cr, out_last}), 64'({1'b1, held}));
      if (out_valid && out_ready) begin
        check("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_out++;
          check("pixel",
                64'({Y, Cb, Cr, out_last, y16, cb16, cr16, last16, out_valid16}),
                64'({e.y, e.cb, e.cr, e.last, e.y16, e.cb, e.cr, e.last, 1'b1}));
        end
      end
      prev_stall = out_valid && !out_ready;
      held       = {Y, Cb, Cr, out_last};
      if (in_valid && in_ready) exp_q.push_back(model(int'(R), int'(G), int'(B), in_last));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_pixel(input logic last);
    R       = 8'($urandom);
    G       = 8'($urandom);
    B       = 8'($urandom);
    in_last = last;
  endtask

  // mode 0: random valid/ready; mode 1: full rate; mode 2: full rate with out_ready low cycles 6..10.
  task automatic stream(input int n, input int mode, input logic tag_end);
    int   i;
    int   cyc;
    logic acc;
    i   = 0;
    cyc = 0;
    new_pixel(tag_end && (n == 1));
    while (i < n && cyc < 4000) begin
      case (mode)
        0: begin
          in_valid  = ($urandom_range(3, 0) != 0);
          out_ready = 1'($urandom_range(1, 0));
        end
        2: begin
          in_valid  = 1'b1;
          out_ready = !(cyc >= 6 && cyc <= 10);
        end
        default: begin
          in_valid  = 1'b1;
          out_ready = 1'b1;
        end
      endcase
      @(negedge clk);
      if (mode == 2 && cyc == 6)  check("ready_at_stall", 64'(in_ready), 64'(SKID));
      if (mode == 2 && cyc == 7)  check("ready_stall_next", 64'(in_ready), 64'd0);
      if (mode == 2 && cyc == 12) check("ready_resumed", 64'(in_ready), 64'd1);
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        i++;
        if (!tag_end) new_pixel(($urandom_range(7, 0) == 0));
        else new_pixel(i == n - 1);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("stream_accepted", 64'(i), 64'(n));
  endtask

  task automatic drain();
    int k;
    k         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 100) begin
      tick();
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int   lat;
    int   base;
    logic seen;

    vecs[0] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 8'd255};
    vecs[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128, 8'd16};
    vecs[2] = '{8'd255, 8'd0,   8'd0,   8'd77,  8'd85,  8'd255, 8'd93};
    vecs[3] = '{8'd0,   8'd0,   8'd255, 8'd29,  8'd255, 8'd107, 8'd45};
    vecs[4] = '{8'd255, 8'd255, 8'd0,   8'd226, 8'd1,   8'd149, 8'd242};
    vecs[5] = '{8'd0,   8'd255, 8'd0,   8'd149, 8'd43,  8'd21,  8'd165};
    vecs[6] = '{8'd128, 8'd64,  8'd32,  8'd80,  8'd101, 8'd163, 8'd96};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    R = 8'd0; G = 8'd0; B = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({out_valid, Y, Cb, Cr, out_last, out_valid16}), 64'd0);
    check("reset_ready", 64'({in_ready, in_ready16}), 64'd3);
    rst_n = 1'b1;
    tick();

    // Corner vectors, one at a time, with latency measured per pixel.
    for (int v = 0; v < 7; v++) begin
      R = vecs[v].r; G = vecs[v].g; B = vecs[v].b;
      in_last   = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_ycbcr", v), 64'({Y, Cb, Cr}), 64'({vecs[v].y, vecs[v].cb, vecs[v].cr}));
      check($sformatf("vec%0d_y16", v), 64'(y16), 64'(vecs[v].y16));
      tick();
      check($sformatf("vec%0d_empty_ready", v), 64'({out_valid, in_ready}), 64'd1);
    end

    // Line tag on the 8th of 8 pixels at full rate.
    stream(8, 1, 1'b1);
    lat = 1;
    while (!(out_valid && out_last) && lat < 20) begin
      tick();
      lat++;
    end
    check("last_latency", 64'(lat), 64'(LAT));
    drain();

    // Output stall under full input rate.
    stream(14, 2, 1'b0);
    drain();

    // Random backpressure: 20 pixels, then a longer random run.
    base = n_out;
    stream(20, 0, 1'b0);
    drain();
    check("bp20_count", 64'(n_out - base), 64'd20);
    base = n_out;
    stream(200, 0, 1'b0);
    drain();
    check("bp200_count", 64'(n_out - base), 64'd200);

    // Reset with three pixels in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      new_pixel(1'b0);
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midreset_outputs", 64'({out_valid, Y, Cb, Cr, out_last, out_valid16}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen = seen | out_valid;
    end
    check("no_stale_pixel", 64'(seen), 64'd0);
    check("post_reset_ready", 64'(in_ready), 64'd1);
    stream(5, 1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
